if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the program counter, drives the instruction memory address
// combinationally from it, and latches the fetched word into the IF/ID
// register. Supports downstream stall, branch/jump redirect (with bubble
// insertion), misaligned-target fault capture and a sticky halt.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst          asynchronous active-low reset
//   stall        hold PC and IF/ID
//   redirect     taken branch/jump resolved downstream
//   redirect_pc  redirect target
//   halt_req     downstream halt request
//   InstAddr     instruction memory address (current PC)
//   InstWord     instruction memory read data for InstAddr
//   if_pc        IF/ID: PC of latched instruction
//   if_inst      IF/ID: latched instruction word
//   if_pc4       IF/ID: if_pc + 4
//   if_valid     IF/ID holds a real instruction
//   if_halt      IF/ID carries a fetch fault (misaligned redirect target)
//   halted       stage stopped, sticky until reset
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] InstAddr,
    input  logic [31:0] InstWord,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        if_halt,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FAULT  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] redirect_pc4_s;
    logic        redirect_misaligned_s;

    // A fetch address is legal only when it is word aligned.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Memory address comes straight from the PC register: no added latency.
    assign InstAddr = pc_r;

    // Sequential PC increment wraps modulo 2^32 by construction.
    assign pc_plus4_s            = pc_r + 32'd4;
    assign redirect_pc4_s        = redirect_pc + 32'd4;
    assign redirect_misaligned_s = !is_word_aligned(redirect_pc);

    // Fetch FSM: PC, state and all IF/ID fields, with halt_req > redirect > stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            if_pc    <= 32'h0000_0000;
            if_inst  <= NOP_INST;
            if_pc4   <= 32'h0000_0000;
            if_valid <= 1'b0;
            if_halt  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req) begin
                        // PC frozen; IF/ID flushed to a plain bubble.
                        state_r  <= ST_HALTED;
                        halted   <= 1'b1;
                        if_pc    <= 32'h0000_0000;
                        if_inst  <= NOP_INST;
                        if_pc4   <= 32'h0000_0000;
                        if_valid <= 1'b0;
                        if_halt  <= 1'b0;
                    end else if (redirect) begin
                        if (redirect_misaligned_s) begin
                            // Capture the bad target in IF/ID so the fault
                            // can be reported downstream; PC is left alone.
                            state_r  <= ST_FAULT;
                            if_pc    <= redirect_pc;
                            if_inst  <= NOP_INST;
                            if_pc4   <= redirect_pc4_s;
                            if_valid <= 1'b0;
                            if_halt  <= 1'b1;
                        end else begin
                            // Wrong-path instruction in IF/ID is squashed.
                            pc_r     <= redirect_pc;
                            if_pc    <= 32'h0000_0000;
                            if_inst  <= NOP_INST;
                            if_pc4   <= 32'h0000_0000;
                            if_valid <= 1'b0;
                            if_halt  <= 1'b0;
                        end
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else begin
                        pc_r     <= pc_plus4_s;
                        if_pc    <= pc_r;
                        if_inst  <= InstWord;
                        if_pc4   <= pc_plus4_s;
                        if_valid <= 1'b1;
                        if_halt  <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (halt_req) begin
                        state_r  <= ST_HALTED;
                        halted   <= 1'b1;
                        if_pc    <= 32'h0000_0000;
                        if_inst  <= NOP_INST;
                        if_pc4   <= 32'h0000_0000;
                        if_valid <= 1'b0;
                        if_halt  <= 1'b0;
                    end else begin
                        // Everything frozen until the halt request arrives.
                        state_r <= ST_FAULT;
                    end
                end
                ST_HALTED: begin
                    // Only reset leaves this state.
                    state_r <= ST_HALTED;
                    halted  <= 1'b1;
                end
                default: begin
                    // Corrupted state encoding: stop safely with a bubble.
                    state_r  <= ST_HALTED;
                    halted   <= 1'b1;
                    if_pc    <= 32'h0000_0000;
                    if_inst  <= NOP_INST;
                    if_pc4   <= 32'h0000_0000;
                    if_valid <= 1'b0;
                    if_halt  <= 1'b0;
                end
            endcase
        end
    end

endmodule
